// File: rtl/bridge_pkg.sv
// Shared constants and types for the serial
// configuration readback path.
package bridge_pkg;

  localparam int DEF_SIZESRSTAT = 88;
  localparam int DEF_SIZESRDYN  = 16;
  localparam int BITCNT_W       = 7;

  localparam logic TGT_DYN  = 1'b1;
  localparam logic TGT_STAT = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  function automatic logic [BITCNT_W-1:0] sat_inc(
    input logic [BITCNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/serial_edge_sync.sv
// Two-flop synchronizers for sclk/sel/miso and a
// rising-edge detector on the synchronized sclk.
module serial_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_sel,
  input  logic i_miso,
  output logic o_capture,
  output logic o_sel,
  output logic o_miso
);

  logic [2:0] r_sclk;
  logic [1:0] r_sel;
  logic [1:0] r_miso;

  // sync stages; r_sclk[2] is the previous synchronized sclk
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk <= '0;
      r_sel  <= '0;
      r_miso <= '0;
    end else begin
      r_sclk <= {r_sclk[1:0], i_sclk};
      r_sel  <= {r_sel[0], i_sel};
      r_miso <= {r_miso[0], i_miso};
    end
  end

  assign o_capture = r_sclk[1] & ~r_sclk[2];
  assign o_sel     = r_sel[1];
  assign o_miso    = r_miso[1];

endmodule

// File: rtl/config_readback_checker.sv
// Reassembles serial readback frames and checks them
// against the expected dynamic/static config words.
module config_readback_checker
  import bridge_pkg::*;
#(
  parameter int SIZESRSTAT = DEF_SIZESRSTAT,
  parameter int SIZESRDYN  = DEF_SIZESRDYN,
  parameter int TIMEOUT    = 64,
  parameter int CNTW       = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  sclk_in,
  input  logic                  sel_in,
  input  logic                  miso_in,
  input  logic                  clear,
  input  logic [SIZESRDYN-1:0]  exp_dyn,
  input  logic [SIZESRSTAT-1:0] exp_stat,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  dyn_ok,
  output logic                  stat_ok,
  output logic [CNTW-1:0]       dyn_err_cnt,
  output logic [CNTW-1:0]       stat_err_cnt
);

  localparam int IW = $clog2(TIMEOUT);
  // CHECK is entered two counts early so that the
  // registered frame_done lands TIMEOUT+1 cycles
  // after the last capture.
  localparam logic [IW-1:0] IDLE_END = IW'(TIMEOUT - 2);

  logic w_capture;
  logic w_sel;
  logic w_miso;

  serial_edge_sync u_sync (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_sclk    (sclk_in),
    .i_sel     (sel_in),
    .i_miso    (miso_in),
    .o_capture (w_capture),
    .o_sel     (w_sel),
    .o_miso    (w_miso)
  );

  state_t                  r_state;
  state_t                  w_nxt;
  logic [BITCNT_W-1:0]     r_bitcnt;
  logic [IW-1:0]           r_idle;
  logic                    r_tgt;
  logic                    r_mixed;
  logic [SIZESRSTAT-1:0]   r_shreg;
  logic                    r_done;
  logic                    r_ferr;
  logic                    r_dyn_ok;
  logic                    r_stat_ok;
  logic [CNTW-1:0]         r_dcnt;
  logic [CNTW-1:0]         r_scnt;

  logic w_start;
  logic w_shift;
  logic w_eval;
  logic w_len_ok;
  logic w_dyn_match;
  logic w_stat_match;

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // next state and frame control strobes
  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_eval  = 1'b0;
    if (clear) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            w_start = 1'b1;
            w_nxt   = SHIFT;
          end
        end
        SHIFT: begin
          if (w_capture)
            w_shift = 1'b1;
          else if (r_idle == IDLE_END)
            w_nxt = CHECK;
        end
        CHECK: begin
          w_eval = 1'b1;
          if (w_capture) begin
            w_start = 1'b1;
            w_nxt   = SHIFT;
          end else begin
            w_nxt = IDLE;
          end
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  // frame length/target validity and word compares
  always_comb begin
    w_len_ok = 1'b0;
    if (r_tgt == TGT_DYN)
      w_len_ok = (r_bitcnt == BITCNT_W'(SIZESRDYN));
    else
      w_len_ok = (r_bitcnt == BITCNT_W'(SIZESRSTAT));
    w_len_ok     = w_len_ok & ~r_mixed;
    w_dyn_match  = (r_shreg[SIZESRDYN-1:0] == exp_dyn);
    w_stat_match = (r_shreg == exp_stat);
  end

  // frame assembly: shift register, bit and idle counts
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bitcnt <= '0;
      r_idle   <= '0;
      r_tgt    <= TGT_STAT;
      r_mixed  <= 1'b0;
      r_shreg  <= '0;
    end else if (clear) begin
      r_bitcnt <= '0;
      r_idle   <= '0;
      r_mixed  <= 1'b0;
    end else if (w_start) begin
      r_tgt    <= w_sel;
      r_bitcnt <= BITCNT_W'(1);
      r_idle   <= '0;
      r_mixed  <= 1'b0;
      r_shreg  <= {{(SIZESRSTAT-1){1'b0}}, w_miso};
    end else if (w_shift) begin
      r_bitcnt <= sat_inc(r_bitcnt);
      r_idle   <= '0;
      r_shreg  <= {r_shreg[SIZESRSTAT-2:0], w_miso};
      if (w_sel != r_tgt) r_mixed <= 1'b1;
    end else if (r_state == SHIFT) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  // result flags, saturating counters, done strobe
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      r_dyn_ok  <= 1'b0;
      r_stat_ok <= 1'b0;
      r_dcnt    <= '0;
      r_scnt    <= '0;
    end else if (clear) begin
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      r_dyn_ok  <= 1'b0;
      r_stat_ok <= 1'b0;
      r_dcnt    <= '0;
      r_scnt    <= '0;
    end else begin
      r_done <= w_eval;
      if (w_eval && !w_len_ok) begin
        r_ferr <= 1'b1;
      end else if (w_eval) begin
        r_ferr <= 1'b0;
        if (r_tgt == TGT_DYN) begin
          r_dyn_ok <= w_dyn_match;
          if (!w_dyn_match && r_dcnt != '1)
            r_dcnt <= r_dcnt + 1'b1;
        end else begin
          r_stat_ok <= w_stat_match;
          if (!w_stat_match && r_scnt != '1)
            r_scnt <= r_scnt + 1'b1;
        end
      end
    end
  end

  assign busy         = (r_state != IDLE);
  assign frame_done   = r_done;
  assign frame_err    = r_ferr;
  assign dyn_ok       = r_dyn_ok;
  assign stat_ok      = r_stat_ok;
  assign dyn_err_cnt  = r_dcnt;
  assign stat_err_cnt = r_scnt;

endmodule

// File: tb/tb_config_readback_checker.sv
// Scoreboard bench for config_readback_checker:
// directed frames, monitor checks on frame_done.
module tb_config_readback_checker;

  localparam int TO   = 16;
  localparam int STAT = 88;
  localparam int DYN  = 16;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            sclk_in;
  logic            sel_in;
  logic            miso_in;
  logic            clear;
  logic [DYN-1:0]  exp_dyn;
  logic [STAT-1:0] exp_stat;
  logic            busy;
  logic            frame_done;
  logic            frame_err;
  logic            dyn_ok;
  logic            stat_ok;
  logic [7:0]      dyn_err_cnt;
  logic [7:0]      stat_err_cnt;

  config_readback_checker #(
    .SIZESRSTAT (STAT),
    .SIZESRDYN  (DYN),
    .TIMEOUT    (TO),
    .CNTW       (8)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .sclk_in      (sclk_in),
    .sel_in       (sel_in),
    .miso_in      (miso_in),
    .clear        (clear),
    .exp_dyn      (exp_dyn),
    .exp_stat     (exp_stat),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .dyn_ok       (dyn_ok),
    .stat_ok      (stat_ok),
    .dyn_err_cnt  (dyn_err_cnt),
    .stat_err_cnt (stat_err_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       dok;
    logic       sok;
    logic       ferr;
    logic [7:0] dcnt;
    logic [7:0] scnt;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;

  logic       m_dok, m_sok, m_ferr;
  logic [7:0] m_dcnt, m_scnt;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  task automatic model_zero();
    m_dok  = 1'b0;
    m_sok  = 1'b0;
    m_ferr = 1'b0;
    m_dcnt = 8'd0;
    m_scnt = 8'd0;
  endtask

  task automatic push_frame(input logic is_dyn,
                            input logic valid,
                            input logic match);
    exp_t e;
    if (valid) begin
      m_ferr = 1'b0;
      if (is_dyn) begin
        m_dok = match;
        if (!match && m_dcnt != 8'hff) m_dcnt++;
      end else begin
        m_sok = match;
        if (!match && m_scnt != 8'hff) m_scnt++;
      end
    end else begin
      m_ferr = 1'b1;
    end
    e.dok  = m_dok;
    e.sok  = m_sok;
    e.ferr = m_ferr;
    e.dcnt = m_dcnt;
    e.scnt = m_scnt;
    q.push_back(e);
  endtask

  // one bit per 8 CLK: data changes on sclk low
  task automatic send_bits(input logic [127:0] data,
                           input int n,
                           input logic sel,
                           input int flip_at);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      sclk_in = 1'b0;
      miso_in = data[n-1-i];
      sel_in  = (flip_at >= 0 && i >= flip_at) ? ~sel : sel;
      repeat (3) @(negedge CLK);
      sclk_in   = 1'b1;
      last_rise = cyc;
      repeat (4) @(negedge CLK);
    end
    @(negedge CLK);
    sclk_in = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (q.size() != 0 && k < TO + 40) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout actual=pending required=empty");
      q.delete();
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic frame(input logic [127:0] data,
                       input int n,
                       input logic sel,
                       input int flip_at,
                       input logic valid,
                       input logic match);
    push_frame(sel, valid, match);
    send_bits(data, n, sel, flip_at);
    wait_done();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_ferr"}, 32'(frame_err), 0);
    chk({tag, "_dok"}, 32'(dyn_ok), 0);
    chk({tag, "_sok"}, 32'(stat_ok), 0);
    chk({tag, "_dcnt"}, 32'(dyn_err_cnt), 0);
    chk({tag, "_scnt"}, 32'(stat_err_cnt), 0);
  endtask

  // monitor: on each frame_done compare latency and results
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (frame_done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = q.pop_front();
          chk("done_latency", 32'(cyc - last_rise),
              32'(TO + 3));
          @(negedge CLK);
          chk("done_pulse", 32'(frame_done), 0);
          chk("dyn_ok", 32'(dyn_ok), 32'(e.dok));
          chk("stat_ok", 32'(stat_ok), 32'(e.sok));
          chk("frame_err", 32'(frame_err), 32'(e.ferr));
          chk("dyn_cnt", 32'(dyn_err_cnt), 32'(e.dcnt));
          chk("stat_cnt", 32'(stat_err_cnt), 32'(e.scnt));
        end
      end
    end
  end

  logic [127:0] w_stat_ok_word;
  logic [127:0] w_stat_bad_word;

  initial begin
    w_stat_ok_word  = 128'hFEDCBA9876543210012345;
    w_stat_bad_word = 128'hFEDCBA9876543210012344;
    RST_N    = 1'b0;
    sclk_in  = 1'b0;
    sel_in   = 1'b0;
    miso_in  = 1'b0;
    clear    = 1'b0;
    exp_dyn  = 16'h4321;
    exp_stat = 88'hFEDCBA9876543210012345;
    model_zero();
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    frame(128'h4321, 16, 1'b1, -1, 1'b1, 1'b1);
    frame(w_stat_ok_word, 88, 1'b0, -1, 1'b1, 1'b1);
    frame(w_stat_bad_word, 88, 1'b0, -1, 1'b1, 1'b0);
    frame(128'h4321, 15, 1'b1, -1, 1'b0, 1'b0);
    frame(128'h14321, 17, 1'b1, -1, 1'b0, 1'b0);
    frame(128'h4321, 16, 1'b1, -1, 1'b1, 1'b1);
    frame(128'h4321, 16, 1'b1, 8, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      frame(128'h1234, 16, 1'b1, -1, 1'b1, 1'b0);
    chk("dcnt_sat", 32'(dyn_err_cnt), 32'd255);

    @(negedge CLK);
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    model_zero();
    #1;
    chk_zero("clear");

    send_bits(128'h4321, 5, 1'b1, -1);
    chk("busy_mid", 32'(busy), 1);
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    repeat (TO + 20) @(negedge CLK);
    chk("abort_busy", 32'(busy), 0);

    frame(128'h4320, 16, 1'b1, -1, 1'b1, 1'b0);
    frame(128'h4321, 16, 1'b1, -1, 1'b1, 1'b1);
    frame(w_stat_ok_word, 88, 1'b0, -1, 1'b1, 1'b1);

    send_bits(128'h4321 >> 6, 10, 1'b1, -1);
    chk("busy_pre_rst", 32'(busy), 1);
    RST_N = 1'b0;
    #1;
    chk_zero("midrst");
    model_zero();
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    frame(128'h4321, 16, 1'b1, -1, 1'b1, 1'b1);
    chk("final_dok", 32'(dyn_ok), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
